rslatch_bank_ctrl: RTL and testbench

- Sequencer and round-robin arbiter for a shared bank of NLATCH RS latches.
- Up to NREQ requesters ask to set or reset one addressed latch.
- The block grants one requester at a time and drives a clean R or S pulse of fixed width, followed by a recovery gap.
- It guarantees that R=S=1 is never presented to any latch, and signals completion.

---
 rtl/rslatch_bank_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_rslatch_bank_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rslatch_bank_ctrl.sv
// Round-robin sequencer for a shared bank of RS latches: one clean R or S pulse per grant, then recovery.
// Optional SHADOW output (expected Q of every latch) enabled by defining RSLATCH_BANK_SHADOW_EN.
module rslatch_bank_ctrl #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned NLATCH      = 8,
  parameter int unsigned AW          = 3,
  parameter int unsigned PULSE_CYC   = 2,
  parameter int unsigned RECOVER_CYC = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      REQ,
  input  logic [NREQ-1:0]      OP,
  input  logic [NREQ*AW-1:0]   ADDR,
  output logic [NREQ-1:0]      GNT,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 ERR,
  output logic [NLATCH-1:0]    R_OUT,
  output logic [NLATCH-1:0]    S_OUT
`ifdef RSLATCH_BANK_SHADOW_EN
  ,
  output logic [NLATCH-1:0]    SHADOW
`endif
);

  localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CMAX = (PULSE_CYC > RECOVER_CYC) ? PULSE_CYC : RECOVER_CYC;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [1:0] {IDLE, PULSE, RECOVER, FIN} state_t;

  state_t              state, state_d;
  logic [PW-1:0]       ptr, ptr_d, win, win_d, pick;
  logic [CW-1:0]       cnt, cnt_d;
  logic                cap_op, cap_op_d, sel_op, found;
  logic [AW-1:0]       cap_addr, cap_addr_d, sel_addr;
  logic [NREQ-1:0]     gnt_d, sel_gnt;
  logic                busy_d, done_d, err_d;
  logic [NLATCH-1:0]   r_d, s_d;
`ifdef RSLATCH_BANK_SHADOW_EN
  logic [NLATCH-1:0]   shadow_d;
`endif

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return 32'(a) < NLATCH;
  endfunction

  // One-hot latch line for an address; out-of-range addresses select nothing.
  function automatic logic [NLATCH-1:0] decode(input logic [AW-1:0] a);
    logic [NLATCH-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NLATCH; i++) v[i] = (32'(a) == i);
    return v;
  endfunction

  // Round-robin pick: first requester at or after ptr, wrapping.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    sel_op   = 1'b0;
    sel_addr = '0;
    sel_gnt  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      for (int unsigned r = 0; r < NREQ; r++) begin
        if (!found && REQ[r] && (r == (32'(ptr) + k) % NREQ)) begin
          found = 1'b1;
          pick  = PW'(r);
        end
      end
    end
    for (int unsigned r = 0; r < NREQ; r++) begin
      if (PW'(r) == pick) begin
        sel_op     = OP[r];
        sel_addr   = ADDR[r*AW +: AW];
        sel_gnt[r] = 1'b1;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state;
    ptr_d      = ptr;
    win_d      = win;
    cnt_d      = cnt;
    cap_op_d   = cap_op;
    cap_addr_d = cap_addr;
    gnt_d      = '0;
    busy_d     = BUSY;
    done_d     = 1'b0;
    err_d      = ERR;
    r_d        = R_OUT;
    s_d        = S_OUT;
`ifdef RSLATCH_BANK_SHADOW_EN
    shadow_d   = SHADOW;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          state_d    = PULSE;
          win_d      = pick;
          cap_op_d   = sel_op;
          cap_addr_d = sel_addr;
          gnt_d      = sel_gnt;
          busy_d     = 1'b1;
          cnt_d      = '0;
          s_d        = sel_op ? decode(sel_addr) : '0;
          r_d        = sel_op ? '0 : decode(sel_addr);
          if (!addr_ok(sel_addr)) err_d = 1'b1;
        end
      end
      PULSE: begin
        if (cnt == CW'(PULSE_CYC - 1)) begin
          state_d = RECOVER;
          cnt_d   = '0;
          r_d     = '0;
          s_d     = '0;
`ifdef RSLATCH_BANK_SHADOW_EN
          if (addr_ok(cap_addr)) shadow_d = (shadow_d & ~decode(cap_addr)) |
                                            (cap_op ? decode(cap_addr) : '0);
`endif
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      RECOVER: begin
        if (cnt == CW'(RECOVER_CYC - 1)) begin
          state_d = FIN;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      FIN: begin
        state_d = IDLE;
        ptr_d   = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any pulse on the same edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      ptr      <= '0;
      win      <= '0;
      cnt      <= '0;
      cap_op   <= 1'b0;
      cap_addr <= '0;
      GNT      <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
      R_OUT    <= '0;
      S_OUT    <= '0;
`ifdef RSLATCH_BANK_SHADOW_EN
      SHADOW   <= '0;
`endif
    end else begin
      state    <= state_d;
      ptr      <= ptr_d;
      win      <= win_d;
      cnt      <= cnt_d;
      cap_op   <= cap_op_d;
      cap_addr <= cap_addr_d;
      GNT      <= gnt_d;
      BUSY     <= busy_d;
      DONE     <= done_d;
      ERR      <= err_d;
      R_OUT    <= r_d;
      S_OUT    <= s_d;
`ifdef RSLATCH_BANK_SHADOW_EN
      SHADOW   <= shadow_d;
`endif
    end
  end

endmodule

// File: tb/tb_rslatch_bank_ctrl.sv
// Self-checking bench for rslatch_bank_ctrl: directed steps plus random traffic against a transaction-timeline model.
module tb_rslatch_bank_ctrl;
  localparam int NR = 4;
  localparam int NL = 6;
  localparam int AW = 3;
  localparam int P  = 2;
  localparam int RC = 1;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [NR-1:0]   REQ = '0;
  logic [NR-1:0]   OP  = '0;
  logic [NR*AW-1:0] ADDR = '0;
  logic [NR-1:0]   GNT;
  logic            BUSY, DONE, ERR;
  logic [NL-1:0]   R_OUT, S_OUT;
`ifdef RSLATCH_BANK_SHADOW_EN
  logic [NL-1:0]   SHADOW;
`endif

  rslatch_bank_ctrl #(.NREQ(NR), .NLATCH(NL), .AW(AW), .PULSE_CYC(P), .RECOVER_CYC(RC)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .OP(OP), .ADDR(ADDR),
    .GNT(GNT), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .R_OUT(R_OUT), .S_OUT(S_OUT)
`ifdef RSLATCH_BANK_SHADOW_EN
    , .SHADOW(SHADOW)
`endif
  );

  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: t = cycles since grant (-1 when idle), winner, captured op/addr, pointer, sticky error, shadow.
  int            t = -1;
  int            m_ptr = 0, m_win = 0, m_addr = 0;
  bit            m_op = 0, m_err = 0;
  logic [NL-1:0] m_shadow = '0;
  logic [NR-1:0] m_gnt;
  bit            hold = 0;
  int            gq[$];
  int            n_done = 0;
  int            waits[NR];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    if (RST) begin
      t = -1; m_ptr = 0; m_err = 0; m_shadow = '0;
    end else if (t < 0) begin
      if (REQ != 0) begin
        for (int k = 0; k < NR; k++) begin
          if (REQ[(m_ptr + k) % NR]) begin m_win = (m_ptr + k) % NR; break; end
        end
        t = 0;
        m_op = OP[m_win];
        m_addr = int'(ADDR[m_win*AW +: AW]);
        if (m_addr >= NL) m_err = 1;
      end
    end else begin
      t++;
      if (t == P && m_addr < NL) m_shadow[m_addr] = m_op;
      if (t == P + RC + 1) begin t = -1; m_ptr = (m_win + 1) % NR; end
    end
  endtask

  task automatic check_all();
    logic [NL-1:0] line;
    m_gnt = (t == 0) ? (NR'(1) << m_win) : '0;
    line  = (t >= 0 && t < P && m_addr < NL) ? (NL'(1) << m_addr) : '0;
    chk("gnt",  64'(GNT),  64'(m_gnt));
    chk("busy", 64'(BUSY), 64'(t >= 0 && t < P + RC));
    chk("done", 64'(DONE), 64'(t == P + RC));
    chk("err",  64'(ERR),  64'(m_err));
    chk("s_out", 64'(S_OUT), 64'(m_op ? line : '0));
    chk("r_out", 64'(R_OUT), 64'(m_op ? '0 : line));
    chk("r_and_s", 64'(R_OUT & S_OUT), 64'(0));
    chk("rs_onehot", 64'($countones(R_OUT | S_OUT) <= 1), 64'(1));
    chk("gnt_onehot", 64'($countones(GNT) <= 1), 64'(1));
`ifdef RSLATCH_BANK_SHADOW_EN
    chk("shadow", 64'(SHADOW), 64'(m_shadow));
`endif
  endtask

  // One clock: model update at the edge, compare 1 time unit later, then requester bookkeeping.
  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    check_all();
    if (DONE) n_done++;
    if (RST) for (int i = 0; i < NR; i++) waits[i] = 0;
    for (int j = 0; j < NR; j++) begin
      if (GNT[j]) begin
        gq.push_back(j);
        for (int i = 0; i < NR; i++) if (i != j && REQ[i]) waits[i]++;
        waits[j] = 0;
        for (int i = 0; i < NR; i++) chk("fair_wait", 64'(waits[i] <= NR - 1), 64'(1));
      end
    end
    if (!hold) REQ = REQ & ~m_gnt;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    RST = 1'b1; REQ = '0;
    run(2);
    RST = 1'b0;
  endtask

  task automatic req1(input int i, input bit op, input int addr);
    OP[i] = op;
    ADDR[i*AW +: AW] = AW'(addr);
    REQ[i] = 1'b1;
  endtask

  initial begin
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};

    // Reset, then a single set on latch 3.
    do_reset();
    chk("rst_busy", 64'(BUSY), 64'(0));
    chk("rst_rs", 64'({R_OUT, S_OUT}), 64'(0));
    req1(0, 1'b1, 3);
    tick();
    chk("single_gnt", 64'(GNT), 64'(4'b0001));
    chk("single_s", 64'(S_OUT), 64'(6'h08));
    run(6);

    // Contention with all requesters held: strict rotation 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < NR; i++) begin OP[i] = 1'b0; ADDR[i*AW +: AW] = AW'(i); end
    gq.delete(); n_done = 0;
    hold = 1; REQ = 4'b1111;
    run(21);
    hold = 0; REQ = '0;
    run(6);
    chk("rr_count", 64'(gq.size()), 64'(5));
    for (int i = 0; i < 5; i++) chk("rr_order", 64'((gq.size() > i) ? gq[i] : -1), 64'(exp_order[i]));
    chk("rr_done", 64'(n_done), 64'(5));

    // Pointer wrap: after serving 3, requester 0 wins over 3.
    do_reset();
    req1(3, 1'b1, 1);
    run(6);
    gq.delete();
    req1(0, 1'b0, 1); req1(3, 1'b1, 2);
    run(12);
    chk("wrap_first", 64'((gq.size() > 0) ? gq[0] : -1), 64'(0));
    chk("wrap_second", 64'((gq.size() > 1) ? gq[1] : -1), 64'(3));

    // Out-of-range address: no line driven, ERR sticky until reset.
    do_reset();
    req1(0, 1'b1, 7);
    run(8);
    chk("oor_err_sticky", 64'(ERR), 64'(1));
    do_reset();
    chk("oor_err_clr", 64'(ERR), 64'(0));

    // Reset during the first S pulse cycle on latch 5.
    req1(0, 1'b1, 5);
    tick();
    chk("midrst_s", 64'(S_OUT), 64'(6'h20));
    RST = 1'b1;
    tick();
    chk("midrst_abort", 64'({BUSY, S_OUT}), 64'(0));
    RST = 1'b0;
    n_done = 0;
    run(6);
    chk("midrst_nodone", 64'(n_done), 64'(0));

    // Shadow sequence: set 2, reset 2, set 5, set 7 (invalid, no change).
    do_reset();
    req1(1, 1'b1, 2); run(6);
    req1(1, 1'b0, 2); run(6);
    req1(1, 1'b1, 5); run(6);
    req1(1, 1'b1, 7); run(6);
`ifdef RSLATCH_BANK_SHADOW_EN
    chk("shadow_final", 64'(SHADOW), 64'(6'h20));
`endif

    // Random traffic: requests raised with random op/addr, occasionally withdrawn.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!REQ[i] && $urandom_range(3) == 0) begin
          req1(i, 1'($urandom_range(1)), int'($urandom_range(7)));
        end else if (REQ[i] && $urandom_range(31) == 0) begin
          REQ[i] = 1'b0;
          waits[i] = 0;
        end
      end
      tick();
    end
    REQ = '0;
    run(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
